// File: rtl/mux_arb_nx1_if.sv
// Handshake bundle between N producers, the selector, and its single consumer.
// The slave modport is the selector's view; the master modport drives producers and consumer.
interface mux_arb_nx1_if #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_arb_nx1.sv
// N-input registered selector with valid/ready handshake.
// Supports directed (external sel) and round-robin arbitration.
module mux_arb_nx1 #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic            sel_err,
    mux_arb_nx1_if.slave    bus
);

    logic            can_load;
    logic            sel_illegal;
    logic            grant_ok;
    logic            xfer;
    logic            rr_found;
    logic [SELW-1:0] rr_grant;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] rr_ptr;

    assign can_load    = !bus.out_valid || bus.out_ready;
    assign sel_illegal = (32'(sel) >= N);

    // First valid channel scanning upward from rr_ptr with wrap.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!rr_found && bus.in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SELW'(idx);
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant    = rr_grant;
            grant_ok = rr_found;
        end else begin
            grant    = sel;
            grant_ok = !sel_illegal;
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (grant_ok) begin
            bus.in_ready[grant] = can_load;
        end
    end

    assign xfer = grant_ok && can_load && bus.in_valid[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            sel_err       <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            sel_err <= !mode && sel_illegal && (|bus.in_valid);
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[grant*WIDTH +: WIDTH];
                bus.out_src   <= grant;
                if (mode) begin
                    rr_ptr <= (32'(grant) == N - 1) ? '0 : grant + 1'b1;
                end
            end else if (bus.out_ready) begin
                // Drain: data and source stay as last loaded.
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1 with a scoreboard-driven output monitor.
// Main instance is N=4; a second N=3 instance exercises illegal select.
module tb_mux_arb_nx1;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic mode4, mode3;
    logic [1:0] sel4, sel3;
    logic sel_err4, sel_err3;

    int tests = 0;
    int fails = 0;

    logic [W+1:0] sb[$];

    mux_arb_nx1_if #(.WIDTH(W), .N(4), .SELW(2)) bus4 ();
    mux_arb_nx1_if #(.WIDTH(W), .N(3), .SELW(2)) bus3 ();

    mux_arb_nx1 #(.WIDTH(W), .N(4), .SELW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .sel_err(sel_err4), .bus(bus4.slave)
    );

    mux_arb_nx1 #(.WIDTH(W), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .sel_err(sel_err3), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic [1:0] s);
        sb.push_back({d, s});
    endtask

    // Monitor: a fresh beat is presented when out_valid rises or follows a consumed beat.
    initial begin
        logic prev_valid;
        logic prev_cons;
        logic [W+1:0] e;
        prev_valid = 1'b0;
        prev_cons  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_cons  = 1'b0;
            end else begin
                if (bus4.out_valid && (!prev_valid || prev_cons)) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", {25'd0, bus4.out_data, bus4.out_src}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", 32'(bus4.out_data), 32'(e[W+1:2]));
                        check("beat_src", 32'(bus4.out_src), 32'(e[1:0]));
                    end
                end
                prev_valid = bus4.out_valid;
                prev_cons  = bus4.out_valid && bus4.out_ready;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        mode4          = 1'b0;
        sel4           = 2'd0;
        mode3          = 1'b0;
        sel3           = 2'd0;
        bus4.in_valid  = '0;
        bus4.in_data   = {5'h1C, 5'h15, 5'h03, 5'h0A};
        bus4.out_ready = 1'b0;
        bus3.in_valid  = '0;
        bus3.in_data   = {5'h11, 5'h12, 5'h13};
        bus3.out_ready = 1'b1;

        step();
        step();
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_out_data", 32'(bus4.out_data), 32'd0);
        check("rst_out_src", 32'(bus4.out_src), 32'd0);
        check("rst_sel_err", 32'(sel_err3), 32'd0);
        rst_n = 1'b1;

        // Illegal select on the 3-channel instance.
        sel3 = 2'd3;
        bus3.in_valid = 3'b111;
        #1;
        check("illegal_in_ready", 32'(bus3.in_ready), 32'd0);
        step();
        check("illegal_sel_err_hi", 32'(sel_err3), 32'd1);
        check("illegal_out_valid", 32'(bus3.out_valid), 32'd0);
        bus3.in_valid = 3'b000;
        step();
        check("illegal_sel_err_lo", 32'(sel_err3), 32'd0);
        check("illegal_out_valid2", 32'(bus3.out_valid), 32'd0);
        sel3 = 2'd2;
        bus3.in_valid = 3'b100;
        #1;
        check("n3_in_ready", 32'(bus3.in_ready), 32'b100);
        step();
        check("n3_out_valid", 32'(bus3.out_valid), 32'd1);
        check("n3_out_data", 32'(bus3.out_data), 32'h11);
        check("n3_out_src", 32'(bus3.out_src), 32'd2);
        bus3.in_valid = 3'b000;

        // Basic directed transfer.
        mode4 = 1'b0;
        sel4 = 2'd2;
        bus4.in_valid = 4'b0100;
        bus4.out_ready = 1'b1;
        #1;
        check("dir_in_ready", 32'(bus4.in_ready), 32'b0100);
        expect_beat(5'h15, 2'd2);
        step();
        check("dir_out_valid", 32'(bus4.out_valid), 32'd1);

        // Backpressure with channel 1 waiting.
        bus4.out_ready = 1'b0;
        sel4 = 2'd1;
        bus4.in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            check("bp_hold_data", 32'(bus4.out_data), 32'h15);
            step();
        end
        bus4.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus4.in_ready), 32'b0010);
        expect_beat(5'h03, 2'd1);
        step();
        check("no_bubble_valid", 32'(bus4.out_valid), 32'd1);
        check("no_bubble_data", 32'(bus4.out_data), 32'h03);
        bus4.in_valid = 4'b0000;
        step();
        check("drain_valid", 32'(bus4.out_valid), 32'd0);
        check("drain_keep_data", 32'(bus4.out_data), 32'h03);

        // Round-robin across all channels, rr_ptr starts at 0.
        mode4 = 1'b1;
        bus4.in_valid = 4'b1111;
        expect_beat(5'h0A, 2'd0);
        expect_beat(5'h03, 2'd1);
        expect_beat(5'h15, 2'd2);
        expect_beat(5'h1C, 2'd3);
        expect_beat(5'h0A, 2'd0);
        expect_beat(5'h03, 2'd1);
        for (int i = 0; i < 6; i++) step();

        // rr_ptr=2: only ch0 valid -> grant 0, rr_ptr becomes 1.
        bus4.in_valid = 4'b0001;
        #1;
        check("rr_wrap_ready", 32'(bus4.in_ready), 32'b0001);
        expect_beat(5'h0A, 2'd0);
        step();
        bus4.in_valid = 4'b1001;
        #1;
        check("rr_skip_ready1", 32'(bus4.in_ready), 32'b1000);
        expect_beat(5'h1C, 2'd3);
        step();
        check("rr_skip_ready2", 32'(bus4.in_ready), 32'b0001);
        expect_beat(5'h0A, 2'd0);
        step();
        check("rr_skip_ready3", 32'(bus4.in_ready), 32'b1000);
        expect_beat(5'h1C, 2'd3);
        step();
        bus4.in_valid = 4'b0000;
        step();

        // Reset while a beat is held under backpressure.
        mode4 = 1'b0;
        sel4 = 2'd2;
        bus4.out_ready = 1'b0;
        bus4.in_valid = 4'b0100;
        expect_beat(5'h15, 2'd2);
        step();
        bus4.in_valid = 4'b0000;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus4.out_valid), 32'd0);
        check("async_rst_data", 32'(bus4.out_data), 32'd0);
        step();
        rst_n = 1'b1;
        mode4 = 1'b1;
        bus4.in_valid = 4'b1111;
        bus4.out_ready = 1'b1;
        expect_beat(5'h0A, 2'd0);
        step();
        check("post_rst_src", 32'(bus4.out_src), 32'd0);
        bus4.in_valid = 4'b0000;
        step();
        step();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
